axi_mem_slave: RTL and testbench

- AXI4 full slave memory model; consumes the DMA master port (s_axi_mosi_t / s_axi_miso_t) in the DMA bench.
- Serves reads and writes from a single byte-strobed word array, one transaction at a time.
- Supports FIXED/INCR bursts, narrow sizes and SLVERR reporting, so DMA read/write engines can be exercised end to end.

---
 rtl/utils_pkg.sv | 89 ++++++++
 rtl/axi_mem_lfsr.sv | 48 ++++
 rtl/axi_mem_slave.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// -----------------------------------------------------------------------------
// utils_pkg
// Shared AXI4 types for the DMA subsystem: field typedefs, the slave-side
// request/response bundles (s_axi_mosi_t / s_axi_miso_t), burst and response
// encodings, the axi_mem_slave FSM state type, and a burst address helper.
// -----------------------------------------------------------------------------
package utils_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_USER_WIDTH = 1;

   typedef logic [AXI_ADDR_WIDTH-1:0]   axi_addr_t;
   typedef logic [AXI_DATA_WIDTH-1:0]   axi_data_t;
   typedef logic [AXI_DATA_WIDTH/8-1:0] axi_strb_t;
   typedef logic [AXI_ID_WIDTH-1:0]     axi_id_t;
   typedef logic [AXI_USER_WIDTH-1:0]   axi_user_t;
   typedef logic [7:0]                  axi_alen_t;
   typedef logic [2:0]                  axi_size_t;
   typedef logic [1:0]                  axi_burst_t;
   typedef logic [1:0]                  axi_resp_t;

   // Master -> slave request bundle
   typedef struct packed {
      axi_id_t    awid;
      axi_addr_t  awaddr;
      axi_alen_t  awlen;
      axi_size_t  awsize;
      axi_burst_t awburst;
      logic       awvalid;
      axi_data_t  wdata;
      axi_strb_t  wstrb;
      logic       wlast;
      logic       wvalid;
      logic       bready;
      axi_id_t    arid;
      axi_addr_t  araddr;
      axi_alen_t  arlen;
      axi_size_t  arsize;
      axi_burst_t arburst;
      logic       arvalid;
      logic       rready;
   } s_axi_mosi_t;

   // Slave -> master response bundle
   typedef struct packed {
      logic       awready;
      logic       wready;
      axi_id_t    bid;
      axi_resp_t  bresp;
      axi_user_t  buser;
      logic       bvalid;
      logic       arready;
      axi_id_t    rid;
      axi_data_t  rdata;
      axi_resp_t  rresp;
      axi_user_t  ruser;
      logic       rlast;
      logic       rvalid;
   } s_axi_miso_t;

   localparam axi_burst_t AXI_FIXED  = 2'b00;
   localparam axi_burst_t AXI_INCR   = 2'b01;
   localparam axi_burst_t AXI_WRAP   = 2'b10;
   localparam axi_resp_t  AXI_OKAY   = 2'b00;
   localparam axi_resp_t  AXI_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2,
      RD_DATA = 2'd3
   } axi_mem_st_t;

   // Address of the following beat; WRAP is walked like INCR (it is errored elsewhere)
   function automatic axi_addr_t axi_next_addr(input axi_addr_t addr,
                                               input axi_size_t size,
                                               input axi_burst_t burst);
      axi_addr_t nxt;
      if (burst == AXI_FIXED) begin
         nxt = addr;
      end else begin
         nxt = addr + (axi_addr_t'(1) << size);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/axi_mem_lfsr.sv
// -----------------------------------------------------------------------------
// axi_mem_lfsr
// Seeded 16-bit Fibonacci LFSR (taps 16,14,13,11) used as a pseudo-random
// stall source. A stall is signalled when the low two state bits are 00.
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset (loads SEED)
//   en_i         advance the sequence this cycle
//   stall_o      stall indication for the current cycle
//   stall_nxt_o  stall indication for the next cycle (lets callers register
//                a valid that must honour next cycle's stall)
// -----------------------------------------------------------------------------
module axi_mem_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic stall_o,
   output logic stall_nxt_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // next-state shift with XOR feedback
   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall_o     = (lfsr_q[1:0] == 2'b00);
   assign stall_nxt_o = (lfsr_d[1:0] == 2'b00);

endmodule

// File: rtl/axi_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_mem_slave
// AXI4 full slave memory model. One transaction at a time out of a single
// byte-strobed word array; FIXED/INCR bursts, narrow sizes, SLVERR on
// out-of-range beats, oversize beats, WRAP bursts and WLAST mismatches.
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset
//   axi_mosi  AXI4 requests from the master (AW/W/B-ready/AR/R-ready)
//   axi_miso  AXI4 responses to the master
// Build option:
//   AXI_MEM_STALL_EN  enables LFSR-driven stalls on awready/wready/arready and
//                     delayed rvalid per beat (axi_mem_lfsr).
// -----------------------------------------------------------------------------
module axi_mem_slave
   import utils_pkg::*;
#(
   parameter int          MEM_KB    = 16,
   parameter axi_addr_t   BASE_ADDR = 32'h0000_0000,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  s_axi_mosi_t axi_mosi,
   output s_axi_miso_t axi_miso
);

   localparam int        STRB_W    = AXI_DATA_WIDTH / 8;
   localparam int        OFF_W     = $clog2(STRB_W);
   localparam int        DEPTH     = MEM_KB * 1024 / STRB_W;
   localparam int        IDX_W     = $clog2(DEPTH);
   localparam axi_addr_t MEM_BYTES = axi_addr_t'(MEM_KB * 1024);
   localparam axi_size_t MAX_SIZE  = axi_size_t'(OFF_W);

   // A beat errs when outside the window, wider than the bus, or part of a WRAP burst
   function automatic logic beat_err(input axi_addr_t a, input axi_size_t s,
                                     input axi_burst_t b);
      axi_addr_t off;
      off = a - BASE_ADDR;
      return (a < BASE_ADDR) || (off >= MEM_BYTES) || (s > MAX_SIZE) || (b == AXI_WRAP);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input axi_addr_t a);
      axi_addr_t off;
      off = (a - BASE_ADDR) >> OFF_W;
      return off[IDX_W-1:0];
   endfunction

   axi_data_t   mem_q [DEPTH];

   axi_mem_st_t state_q,    state_d;
   logic        act_q;
   logic        wr_first_q, wr_first_d;
   axi_id_t     id_q,       id_d;
   axi_addr_t   addr_q,     addr_d;
   axi_alen_t   len_q,      len_d;
   axi_size_t   size_q,     size_d;
   axi_burst_t  burst_q,    burst_d;
   axi_alen_t   cnt_q,      cnt_d;
   logic        err_q,      err_d;
   logic        bvalid_q,   bvalid_d;
   axi_resp_t   bresp_q,    bresp_d;
   logic        rvalid_q,   rvalid_d;
   logic        rpend_q,    rpend_d;
   axi_data_t   rdata_q,    rdata_d;
   axi_resp_t   rresp_q,    rresp_d;
   logic        rlast_q,    rlast_d;

   logic        stall_s;
   logic        rv_stall_s;
   logic        sel_wr_s;
   logic        awready_s;
   logic        arready_s;
   logic        wready_s;
   logic        w_hs_s;
   logic        r_hs_s;
   logic        wr_last_s;
   logic        wr_beat_err_s;
   logic        mem_we_s;
   axi_addr_t   addr_nxt_s;
   axi_addr_t   ld_addr_s;
   axi_size_t   ld_size_s;
   axi_burst_t  ld_burst_s;
   logic        ld_err_s;
   axi_data_t   ld_data_s;

`ifdef AXI_MEM_STALL_EN
   axi_mem_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk         (clk),
      .rst_n       (rst),
      .en_i        (1'b1),
      .stall_o     (stall_s),
      .stall_nxt_o (rv_stall_s)
   );
`else
   // No stall source; the seed only matters to the stall generator
   assign stall_s    = 1'b0 & (|LFSR_SEED);
   assign rv_stall_s = 1'b0;
`endif

   // Arbitration: a lone request wins; contention goes to the pointer
   assign sel_wr_s  = axi_mosi.awvalid && (!axi_mosi.arvalid || wr_first_q);
   assign awready_s = act_q && (state_q == IDLE) && sel_wr_s && !stall_s;
   assign arready_s = act_q && (state_q == IDLE) && axi_mosi.arvalid && !sel_wr_s && !stall_s;
   assign wready_s  = (state_q == WR_DATA) && !stall_s;
   assign w_hs_s    = wready_s && axi_mosi.wvalid;
   assign r_hs_s    = rvalid_q && axi_mosi.rready;

   assign addr_nxt_s    = axi_next_addr(addr_q, size_q, burst_q);
   assign wr_last_s     = (cnt_q == len_q);
   assign wr_beat_err_s = beat_err(addr_q, size_q, burst_q);
   assign mem_we_s      = w_hs_s && !wr_beat_err_s;

   // Read beat source: AR fields for the first beat, else the following address
   always_comb begin
      ld_addr_s  = addr_nxt_s;
      ld_size_s  = size_q;
      ld_burst_s = burst_q;
      if (state_q == IDLE) begin
         ld_addr_s  = axi_mosi.araddr;
         ld_size_s  = axi_mosi.arsize;
         ld_burst_s = axi_mosi.arburst;
      end else begin
         ld_addr_s  = addr_nxt_s;
         ld_size_s  = size_q;
         ld_burst_s = burst_q;
      end
      ld_err_s  = beat_err(ld_addr_s, ld_size_s, ld_burst_s);
      ld_data_s = ld_err_s ? '0 : mem_q[word_idx(ld_addr_s)];
   end

   // FSM next state and registered response fields
   always_comb begin
      state_d    = state_q;
      wr_first_d = wr_first_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rpend_d    = rpend_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      case (state_q)
         IDLE: begin
            if (awready_s) begin
               id_d       = axi_mosi.awid;
               addr_d     = axi_mosi.awaddr;
               len_d      = axi_mosi.awlen;
               size_d     = axi_mosi.awsize;
               burst_d    = axi_mosi.awburst;
               cnt_d      = 8'd0;
               err_d      = 1'b0;
               wr_first_d = axi_mosi.arvalid ? 1'b0 : wr_first_q;
               state_d    = WR_DATA;
            end else if (arready_s) begin
               id_d       = axi_mosi.arid;
               addr_d     = axi_mosi.araddr;
               len_d      = axi_mosi.arlen;
               size_d     = axi_mosi.arsize;
               burst_d    = axi_mosi.arburst;
               cnt_d      = 8'd0;
               rdata_d    = ld_data_s;
               rresp_d    = ld_err_s ? AXI_SLVERR : AXI_OKAY;
               rlast_d    = (axi_mosi.arlen == 8'd0);
               rvalid_d   = !rv_stall_s;
               rpend_d    = rv_stall_s;
               wr_first_d = axi_mosi.awvalid ? 1'b1 : wr_first_q;
               state_d    = RD_DATA;
            end else begin
               state_d    = IDLE;
            end
         end
         WR_DATA: begin
            if (w_hs_s) begin
               // sticky error, including WLAST disagreeing with the beat count
               err_d = err_q | wr_beat_err_s | (axi_mosi.wlast != wr_last_s);
               if (wr_last_s) begin
                  bvalid_d = 1'b1;
                  bresp_d  = err_d ? AXI_SLVERR : AXI_OKAY;
                  state_d  = WR_RESP;
               end else begin
                  cnt_d    = cnt_q + 8'd1;
                  addr_d   = addr_nxt_s;
               end
            end else begin
               state_d = WR_DATA;
            end
         end
         WR_RESP: begin
            if (axi_mosi.bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end else begin
               state_d  = WR_RESP;
            end
         end
         RD_DATA: begin
            if (rpend_q) begin
               // beat already loaded, waiting out a stall before raising rvalid
               rvalid_d = !rv_stall_s;
               rpend_d  = rv_stall_s;
            end else if (r_hs_s) begin
               if (rlast_q) begin
                  rvalid_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  cnt_d    = cnt_q + 8'd1;
                  addr_d   = addr_nxt_s;
                  rdata_d  = ld_data_s;
                  rresp_d  = ld_err_s ? AXI_SLVERR : AXI_OKAY;
                  rlast_d  = ((cnt_q + 8'd1) == len_q);
                  rvalid_d = !rv_stall_s;
                  rpend_d  = rv_stall_s;
               end
            end else begin
               state_d = RD_DATA;
            end
         end
         default: begin
            state_d  = IDLE;
            bvalid_d = 1'b0;
            rvalid_d = 1'b0;
            rpend_d  = 1'b0;
         end
      endcase
   end

   // Control and response registers; act_q keeps the address channels quiet in reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         act_q      <= 1'b0;
         wr_first_q <= 1'b1;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= 8'd0;
         size_q     <= 3'd0;
         burst_q    <= 2'b00;
         cnt_q      <= 8'd0;
         err_q      <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         rvalid_q   <= 1'b0;
         rpend_q    <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= 2'b00;
         rlast_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         act_q      <= 1'b1;
         wr_first_q <= wr_first_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rpend_q    <= rpend_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rlast_q    <= rlast_d;
      end
   end

   // Byte-lane writes into the array; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_mosi.wstrb[b]) begin
               mem_q[word_idx(addr_q)][8*b +: 8] <= axi_mosi.wdata[8*b +: 8];
            end
         end
      end
   end

   // Response bundle assembly
   always_comb begin
      axi_miso         = '0;
      axi_miso.awready = awready_s;
      axi_miso.wready  = wready_s;
      axi_miso.bid     = id_q;
      axi_miso.bresp   = bresp_q;
      axi_miso.bvalid  = bvalid_q;
      axi_miso.arready = arready_s;
      axi_miso.rid     = id_q;
      axi_miso.rdata   = rdata_q;
      axi_miso.rresp   = rresp_q;
      axi_miso.rlast   = rlast_q;
      axi_miso.rvalid  = rvalid_q;
   end

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
   import utils_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;

   int total = 0;
   int bad   = 0;

   logic [31:0] wd [16];
   logic [3:0]  wstrb_v;
   logic [31:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [3:0]  rid_v;
   logic [1:0]  bresp_v;
   logic [3:0]  bid_v;
   logic        stable_v;

   always #5 clk = ~clk;

   axi_mem_slave #(
      .MEM_KB    (16),
      .BASE_ADDR (32'h0000_0000),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .axi_mosi (mosi),
      .axi_miso (miso)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst  = 1'b0;
      mosi = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      logic got;
      @(posedge clk); #1;
      mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len;
      mosi.awsize = size; mosi.awburst = burst; mosi.awvalid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.awready; end
      if (!got) begin total++; bad++; $display("FAIL aw_timeout awready=0 want 1"); end
      @(posedge clk); #1;
      mosi.awvalid = 1'b0;
   endtask

   task automatic finish_write(input logic [7:0] len, input int last_at);
      logic got;
      for (int b = 0; b <= int'(len); b++) begin
         mosi.wdata  = wd[b];
         mosi.wstrb  = wstrb_v;
         mosi.wlast  = (last_at < 0) ? (b == int'(len)) : (b == last_at);
         mosi.wvalid = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.wready; end
         if (!got) begin total++; bad++; $display("FAIL w_timeout beat=%0d wready=0 want 1", b); end
         @(posedge clk); #1;
      end
      mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.bready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.bvalid; end
      if (!got) begin total++; bad++; $display("FAIL b_timeout bvalid=0 want 1"); end
      bresp_v = miso.bresp; bid_v = miso.bid;
      @(posedge clk); #1;
      mosi.bready = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at);
      aw_phase(id, addr, len, size, burst);
      finish_write(len, last_at);
   endtask

   task automatic finish_read(input logic [7:0] len, input int stall_beat);
      logic got;
      stable_v = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         mosi.rready = (b != stall_beat);
         got = 1'b0;
         for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.rvalid; end
         if (!got) begin total++; bad++; $display("FAIL r_timeout beat=%0d rvalid=0 want 1", b); end
         rd[b] = miso.rdata; rr[b] = miso.rresp; rl[b] = miso.rlast; rid_v = miso.rid;
         if (b == stall_beat) begin
            repeat (3) begin
               @(negedge clk);
               if (!miso.rvalid || miso.rdata !== rd[b] || miso.rlast !== rl[b] || miso.rresp !== rr[b])
                  stable_v = 1'b0;
            end
            mosi.rready = 1'b1;
         end
         @(posedge clk); #1;
      end
      mosi.rready = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
      logic got;
      @(posedge clk); #1;
      mosi.arid = id; mosi.araddr = addr; mosi.arlen = len;
      mosi.arsize = size; mosi.arburst = burst; mosi.arvalid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.arready; end
      if (!got) begin total++; bad++; $display("FAIL ar_timeout arready=0 want 1"); end
      @(posedge clk); #1;
      mosi.arvalid = 1'b0;
      finish_read(len, stall_beat);
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      mosi = '0;
      #3;
      total++; if (miso !== '0) begin bad++; $display("FAIL reset_async miso=%h want 0", miso); end
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      @(negedge clk);
      total++; if (miso !== '0) begin bad++; $display("FAIL reset_idle miso=%h want 0", miso); end
   endtask

   task automatic test_single();
      wd[0] = 32'hDEADBEEF; wstrb_v = 4'hF;
      do_write(4'd3, 32'h0000_0040, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (bresp_v !== AXI_OKAY) begin bad++; $display("FAIL single_bresp got=%h want=0", bresp_v); end
      total++; if (bid_v !== 4'd3) begin bad++; $display("FAIL single_bid got=%h want=3", bid_v); end
      do_read(4'd5, 32'h0000_0040, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h want=deadbeef", rd[0]); end
      total++; if (rl[0] !== 1'b1) begin bad++; $display("FAIL single_rlast got=%b want=1", rl[0]); end
      total++; if (rid_v !== 4'd5) begin bad++; $display("FAIL single_rid got=%h want=5", rid_v); end
      total++; if (rr[0] !== AXI_OKAY) begin bad++; $display("FAIL single_rresp got=%h want=0", rr[0]); end
   endtask

   task automatic test_incr_burst();
      for (int i = 0; i < 8; i++) wd[i] = 32'(i);
      wstrb_v = 4'hF;
      do_write(4'd1, 32'h0000_0100, 8'd7, 3'd2, AXI_INCR, -1);
      total++; if (bresp_v !== AXI_OKAY) begin bad++; $display("FAIL incr_bresp got=%h want=0", bresp_v); end
      do_read(4'd2, 32'h0000_0100, 8'd7, 3'd2, AXI_INCR, 3);
      for (int i = 0; i < 8; i++) begin
         total++; if (rd[i] !== 32'(i)) begin bad++; $display("FAIL incr_rdata beat=%0d got=%h want=%h", i, rd[i], i); end
         total++; if (rl[i] !== (i == 7)) begin bad++; $display("FAIL incr_rlast beat=%0d got=%b want=%b", i, rl[i], i == 7); end
      end
      total++; if (stable_v !== 1'b1) begin bad++; $display("FAIL incr_stall_stable got=%b want=1", stable_v); end
   endtask

   task automatic test_fixed();
      wd[0] = 32'hA5A5A5A5; wstrb_v = 4'hF;
      do_write(4'd1, 32'h0000_0200, 8'd0, 3'd2, AXI_INCR, -1);
      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44; wstrb_v = 4'b0001;
      do_write(4'd1, 32'h0000_0200, 8'd3, 3'd2, AXI_FIXED, -1);
      total++; if (bresp_v !== AXI_OKAY) begin bad++; $display("FAIL fixed_bresp got=%h want=0", bresp_v); end
      do_read(4'd1, 32'h0000_0200, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (rd[0] !== 32'hA5A5A544) begin bad++; $display("FAIL fixed_rdata got=%h want=a5a5a544", rd[0]); end
   endtask

   task automatic test_errors();
      wd[0] = 32'h12345678; wstrb_v = 4'hF;
      do_write(4'd1, 32'h0000_0000, 8'd0, 3'd2, AXI_INCR, -1);
      wd[0] = 32'hFFFFFFFF;
      do_write(4'd1, 32'h0000_4000, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (bresp_v !== AXI_SLVERR) begin bad++; $display("FAIL oor_bresp got=%h want=2", bresp_v); end
      do_read(4'd1, 32'h0000_0000, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (rd[0] !== 32'h12345678) begin bad++; $display("FAIL oor_no_alias got=%h want=12345678", rd[0]); end
      do_read(4'd1, 32'h0000_4000, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (rd[0] !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h want=0", rd[0]); end
      total++; if (rr[0] !== AXI_SLVERR) begin bad++; $display("FAIL oor_rresp got=%h want=2", rr[0]); end
      wd[0] = 32'h0;
      do_write(4'd1, 32'h0000_0040, 8'd0, 3'd3, AXI_INCR, -1);
      total++; if (bresp_v !== AXI_SLVERR) begin bad++; $display("FAIL size_bresp got=%h want=2", bresp_v); end
      do_read(4'd1, 32'h0000_0040, 8'd0, 3'd2, AXI_INCR, -1);
      total++; if (rd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL size_no_write got=%h want=deadbeef", rd[0]); end
      do_read(4'd1, 32'h0000_0040, 8'd0, 3'd2, AXI_WRAP, -1);
      total++; if (rr[0] !== AXI_SLVERR) begin bad++; $display("FAIL wrap_rresp got=%h want=2", rr[0]); end
   endtask

   task automatic test_arbitration();
      logic got;
      logic gw;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         mosi.awid = 4'(i); mosi.awaddr = 32'h0000_0300; mosi.awlen = 8'd0;
         mosi.awsize = 3'd2; mosi.awburst = AXI_INCR; mosi.awvalid = 1'b1;
         mosi.arid = 4'(i); mosi.araddr = 32'h0000_0300; mosi.arlen = 8'd0;
         mosi.arsize = 3'd2; mosi.arburst = AXI_INCR; mosi.arvalid = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.awready | miso.arready; end
         gw = miso.awready;
         total++; if (miso.awready && miso.arready) begin bad++; $display("FAIL arb_both txn=%0d got=both want=one", i); end
         total++; if (gw !== (i % 2 == 0)) begin bad++; $display("FAIL arb_order txn=%0d got_write=%b want=%b", i, gw, i % 2 == 0); end
         @(posedge clk); #1;
         mosi.awvalid = 1'b0; mosi.arvalid = 1'b0;
         if (gw) begin
            wd[0] = 32'(i); wstrb_v = 4'hF;
            finish_write(8'd0, -1);
         end else begin
            finish_read(8'd0, -1);
         end
      end
      for (int i = 0; i < 4; i++) wd[i] = 32'h100 + 32'(i);
      wstrb_v = 4'hF;
      do_write(4'd7, 32'h0000_0500, 8'd3, 3'd2, AXI_INCR, 1);
      total++; if (bresp_v !== AXI_SLVERR) begin bad++; $display("FAIL early_wlast got=%h want=2", bresp_v); end
      total++; if (bid_v !== 4'd7) begin bad++; $display("FAIL early_wlast_bid got=%h want=7", bid_v); end
      do_write(4'd7, 32'h0000_0500, 8'd3, 3'd2, AXI_INCR, 99);
      total++; if (bresp_v !== AXI_SLVERR) begin bad++; $display("FAIL missing_wlast got=%h want=2", bresp_v); end
      do_write(4'd7, 32'h0000_0500, 8'd3, 3'd2, AXI_INCR, -1);
      total++; if (bresp_v !== AXI_OKAY) begin bad++; $display("FAIL good_wlast got=%h want=0", bresp_v); end
   endtask

   task automatic test_reset_mid_burst();
      logic got;
      @(posedge clk); #1;
      mosi.arid = 4'd2; mosi.araddr = 32'h0000_0100; mosi.arlen = 8'd7;
      mosi.arsize = 3'd2; mosi.arburst = AXI_INCR; mosi.arvalid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin @(negedge clk); got = miso.arready; end
      @(posedge clk); #1;
      mosi.arvalid = 1'b0; mosi.rready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      total++; if (miso.rvalid !== 1'b1) begin bad++; $display("FAIL mid_burst_active rvalid=%b want=1", miso.rvalid); end
      rst = 1'b0;
      #1;
      total++; if (miso !== '0) begin bad++; $display("FAIL mid_reset_miso got=%h want=0", miso); end
      mosi.rready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      do_read(4'd6, 32'h0000_0100, 8'd7, 3'd2, AXI_INCR, -1);
      for (int i = 0; i < 8; i++) begin
         total++; if (rd[i] !== 32'(i)) begin bad++; $display("FAIL post_reset_rdata beat=%0d got=%h want=%h", i, rd[i], i); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr_burst();
      test_fixed();
      test_errors();
      test_arbitration();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
